// File: rtl/cpu_mem_responder_if.sv
// cpu_mem_responder_if: CPU request/response bus and host loader port
interface cpu_mem_responder_if #(parameter int ADDR_W = 16, parameter int DATA_W = 8);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              err;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  modport master (output req, we, addr, wdata, ld_valid, ld_addr, ld_data,
                  input rdata, ready, err, ld_ready);
  modport slave  (input req, we, addr, wdata, ld_valid, ld_addr, ld_data,
                  output rdata, ready, err, ld_ready);
endinterface

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: RAM + I/O window responder with wait states; MEM_WRITE_PROTECT_EN guards low RAM from CPU writes
module cpu_mem_responder #(
  parameter int              ADDR_W      = 16,
  parameter int              DATA_W      = 8,
  parameter int              RAM_DEPTH   = 256,
  parameter logic [ADDR_W-1:0] IO_BASE   = 16'hFF00,
  parameter int              WAIT_CYCLES = 1,
  parameter int              PROTECT_TOP = 16
) (
  input  logic              clk,
  input  logic              rst,
  cpu_mem_responder_if.slave bus,
  output logic [DATA_W-1:0] io_out,
  input  logic [DATA_W-1:0] io_in
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam logic [ADDR_W-1:0] RAM_TOP = ADDR_W'(RAM_DEPTH);
  localparam logic [ADDR_W-1:0] PTOP = ADDR_W'(PROTECT_TOP);
`ifdef MEM_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] c_addr;
  logic              c_we;
  logic [DATA_W-1:0] c_wdata;
  logic [DATA_W-1:0] mem [RAM_DEPTH];
  logic [DATA_W-1:0] io_s1, io_s2;
  logic              ld_seen;
  logic [ADDR_W-1:0] off;
  logic              ram_hit, is_io0, is_io1, is_io2, wr_ram, bad, ld_acc;
  logic [DATA_W-1:0] rd_val;
  assign bus.ld_ready = (state == S_IDLE) & ~bus.req;
  assign ld_acc = bus.ld_valid & bus.ld_ready & rst;
  always_comb begin
    off     = c_addr - IO_BASE;
    ram_hit = c_addr < RAM_TOP;
    is_io0  = off == '0;
    is_io1  = off == ADDR_W'(1);
    is_io2  = off == ADDR_W'(2);
    wr_ram  = ram_hit & ~(PROT & (c_addr < PTOP));
    rd_val  = ram_hit ? mem[c_addr[AW-1:0]] :
              is_io0  ? io_out :
              is_io1  ? io_s2 :
              is_io2  ? {{(DATA_W-2){1'b0}}, ld_seen, 1'b1} : '0;
    bad     = c_we ? ~(wr_ram | is_io0) : ~(ram_hit | is_io0 | is_io1 | is_io2);
  end
  // CPU writes happen only in RESP and loader writes only in IDLE, so they never collide
  always_ff @(posedge clk) begin
    if (rst && state == S_RESP && c_we && wr_ram) mem[c_addr[AW-1:0]] <= c_wdata;
    else if (ld_acc && bus.ld_addr < RAM_TOP) mem[bus.ld_addr[AW-1:0]] <= bus.ld_data;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bus.rdata <= '0;
      bus.ready <= 1'b0;
      bus.err   <= 1'b0;
      io_out    <= '0;
      io_s1     <= '0;
      io_s2     <= '0;
      ld_seen   <= 1'b0;
    end else begin
      io_s1     <= io_in;
      io_s2     <= io_s1;
      bus.ready <= 1'b0;
      bus.err   <= 1'b0;
      if (ld_acc) ld_seen <= 1'b1;
      case (state)
        S_IDLE: if (bus.req) begin
          c_addr  <= bus.addr;
          c_we    <= bus.we;
          c_wdata <= bus.wdata;
          cnt     <= 4'(WAIT_CYCLES - 1);
          state   <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == '0) state <= S_RESP;
        end
        S_RESP: begin
          bus.ready <= 1'b1;
          bus.err   <= bad;
          if (!c_we) bus.rdata <= rd_val;
          if (c_we && is_io0) io_out <= c_wdata;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: directed checks of decode, latency, loader arbitration and reset abort
module tb_cpu_mem_responder;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] io_out, io_in;
  logic [7:0] q;
  logic       e;
  int         n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  cpu_mem_responder_if #(.ADDR_W(16), .DATA_W(8)) bus ();
  cpu_mem_responder dut (.clk(clk), .rst(rst), .bus(bus.slave), .io_out(io_out), .io_in(io_in));
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 16'(n), 16'd2);
  endtask
  task automatic cpu(input string tag, input logic w, input logic [15:0] a, input logic [7:0] d,
                     output logic [7:0] rq, output logic re);
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1 bus.req = 1'b0;
    wait_ready(tag);
    rq = bus.rdata;
    re = bus.err;
  endtask
  task automatic ld(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.ld_valid = 1'b1; bus.ld_addr = a; bus.ld_data = d;
    @(posedge clk); #1 bus.ld_valid = 1'b0;
  endtask
  initial begin
    int pulses;
    rst = 1'b0; io_in = 8'h00;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", bus.ready, 16'd0);
    check("rst_err", bus.err, 16'd0);
    check("rst_rdata", bus.rdata, 16'h00);
    check("rst_io_out", io_out, 16'h00);
    check("rst_ld_ready", bus.ld_ready, 16'd1);
    @(negedge clk) rst = 1'b1;
    cpu("lat_stat0", 1'b0, 16'hFF02, 8'h00, q, e);
    check("status_fresh", q, 16'h01);
    check("status_err", e, 16'd0);
    @(posedge clk); #1 check("ready_pulse", bus.ready, 16'd0);
    ld(16'h0000, 8'h5A);
    cpu("lat_rd0", 1'b0, 16'h0000, 8'h00, q, e);
    check("rd_ram0", q, 16'h5A);
    check("rd_ram0_err", e, 16'd0);
    check("io_out_idle", io_out, 16'h00);
    ld(16'h0010, 8'h05);
    ld(16'h0011, 8'hA7);
    cpu("lat_rd10", 1'b0, 16'h0010, 8'h00, q, e);
    check("rd_10", q, 16'h05);
    cpu("lat_rd11", 1'b0, 16'h0011, 8'h00, q, e);
    check("rd_11", q, 16'hA7);
    cpu("lat_stat1", 1'b0, 16'hFF02, 8'h00, q, e);
    check("status_loaded", q, 16'h03);
    cpu("lat_wio", 1'b1, 16'hFF00, 8'h3C, q, e);
    check("io_out_wr", io_out, 16'h3C);
    check("io_out_wr_err", e, 16'd0);
    cpu("lat_rio", 1'b0, 16'hFF00, 8'h00, q, e);
    check("rd_io0", q, 16'h3C);
    io_in = 8'h81;
    repeat (3) @(posedge clk);
    cpu("lat_rin", 1'b0, 16'hFF01, 8'h00, q, e);
    check("rd_io_in", q, 16'h81);
    check("rd_io_in_err", e, 16'd0);
    cpu("lat_unm_rd", 1'b0, 16'h1234, 8'h00, q, e);
    check("unmapped_rd_err", e, 16'd1);
    check("unmapped_rd_data", q, 16'h00);
    cpu("lat_unm_wr", 1'b1, 16'hFFF0, 8'h99, q, e);
    check("unmapped_wr_err", e, 16'd1);
    check("unmapped_wr_io", io_out, 16'h3C);
    cpu("lat_alias", 1'b1, 16'h1210, 8'h77, q, e);
    check("alias_wr_err", e, 16'd1);
    cpu("lat_io1_wr", 1'b1, 16'hFF01, 8'h55, q, e);
    check("io1_wr_err", e, 16'd1);
    cpu("lat_io2_wr", 1'b1, 16'hFF02, 8'h55, q, e);
    check("io2_wr_err", e, 16'd1);
    cpu("lat_io3_rd", 1'b0, 16'hFF03, 8'h00, q, e);
    check("io3_rd_err", e, 16'd1);
    check("io3_rd_data", q, 16'h00);
    cpu("lat_alias_rd", 1'b0, 16'h0010, 8'h00, q, e);
    check("ram_unchanged", q, 16'h05);
    check("io_unchanged", io_out, 16'h3C);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'h0020; bus.wdata = 8'h22;
    bus.ld_valid = 1'b1; bus.ld_addr = 16'h0020; bus.ld_data = 8'h6E;
    #1 check("ld_stall_req", bus.ld_ready, 16'd0);
    @(posedge clk); #1 bus.req = 1'b0;
    check("ld_stall_wait", bus.ld_ready, 16'd0);
    wait_ready("lat_collide");
    check("collide_err", bus.err, 16'd0);
    check("ld_ready_after", bus.ld_ready, 16'd1);
    @(posedge clk); #1 bus.ld_valid = 1'b0;
    cpu("lat_rd20", 1'b0, 16'h0020, 8'h00, q, e);
    check("loader_after_cpu", q, 16'h6E);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'h0010; bus.wdata = 8'h44;
    @(posedge clk); #1 bus.req = 1'b0;
    @(negedge clk) rst = 1'b0;
    pulses = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.ready) pulses++;
    end
    @(negedge clk) rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.ready) pulses++;
    end
    check("abort_no_ready", 16'(pulses), 16'd0);
    check("abort_io_out", io_out, 16'h00);
    cpu("lat_abort_rd", 1'b0, 16'h0010, 8'h00, q, e);
    check("abort_no_write", q, 16'h05);
    cpu("lat_stat2", 1'b0, 16'hFF02, 8'h00, q, e);
    check("status_cleared", q, 16'h01);
    ld(16'h0003, 8'h12);
    cpu("lat_prot_wr", 1'b1, 16'h0003, 8'hFF, q, e);
`ifdef MEM_WRITE_PROTECT_EN
    check("prot_wr_err", e, 16'd1);
    cpu("lat_prot_rd", 1'b0, 16'h0003, 8'h00, q, e);
    check("prot_ram_kept", q, 16'h12);
    ld(16'h0003, 8'hFF);
    cpu("lat_prot_rd2", 1'b0, 16'h0003, 8'h00, q, e);
    check("prot_loader_wr", q, 16'hFF);
`else
    check("noprot_wr_err", e, 16'd0);
    cpu("lat_noprot_rd", 1'b0, 16'h0003, 8'h00, q, e);
    check("noprot_wr", q, 16'hFF);
`endif
    cpu("lat_top_wr", 1'b1, 16'h0010, 8'h9D, q, e);
    check("top_wr_err", e, 16'd0);
    cpu("lat_top_rd", 1'b0, 16'h0010, 8'h00, q, e);
    check("top_wr_data", q, 16'h9D);
    ld(16'h0100, 8'hEE);
    cpu("lat_ld_oob", 1'b0, 16'h0000, 8'h00, q, e);
    check("ld_oob_ignored", q, 16'h5A);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
